// File: rtl/lsb_queue_mc.sv
// lsb_queue_mc: in-order load/store queue between dispatch, ROB and memory controller.
// Ports: clk/rst (sync, active-high, qualified by rdy), rdy global enable, flush, stall,
//   io_full; enq_* dispatch request with base/data operands (value or producer tag);
//   cdb_valid/cdb_tag/cdb_val packed broadcast channels; mem_busy; commit_store;
//   full/empty; front_* head-entry view; mem_req_* registered one-cycle load request.
// Optional macro LSB_STORE_FWD_EN adds fwd_valid/fwd_val/fwd_rob_id store-to-load forwarding.
module lsb_queue_mc #(
    parameter int XLEN = 32,
    parameter int DEPTH = 8,
    parameter int ROB_W = 4,
    parameter int OP_W = 6,
    parameter int NUM_CDB = 2,
    parameter logic [XLEN-1:0] IO_ADDR = XLEN'(32'h30000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     io_full,
    input  logic                     enq_valid,
    input  logic                     enq_is_load,
    input  logic [OP_W-1:0]          enq_op,
    input  logic [ROB_W-1:0]         enq_rob_id,
    input  logic [XLEN-1:0]          enq_imm,
    input  logic                     enq_base_rdy,
    input  logic [XLEN-1:0]          enq_base_val,
    input  logic [ROB_W-1:0]         enq_base_tag,
    input  logic                     enq_data_rdy,
    input  logic [XLEN-1:0]          enq_data_val,
    input  logic [ROB_W-1:0]         enq_data_tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
    input  logic                     mem_busy,
    input  logic                     commit_store,
    output logic                     full,
    output logic                     empty,
    output logic                     front_is_load,
    output logic [OP_W-1:0]          front_op,
    output logic [ROB_W-1:0]         front_rob_id,
    output logic                     front_addr_rdy,
    output logic [XLEN-1:0]          front_addr,
    output logic                     front_data_rdy,
    output logic [XLEN-1:0]          front_data,
    output logic                     mem_req_valid,
    output logic [OP_W-1:0]          mem_req_op,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [ROB_W-1:0]         mem_req_rob_id
`ifdef LSB_STORE_FWD_EN
    ,
    output logic                     fwd_valid,
    output logic [XLEN-1:0]          fwd_val,
    output logic [ROB_W-1:0]         fwd_rob_id
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [IW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic             e_valid    [DEPTH];
    logic             e_is_load  [DEPTH];
    logic             e_addr_rdy [DEPTH];
    logic             e_data_rdy [DEPTH];
    logic [OP_W-1:0]  e_op       [DEPTH];
    logic [ROB_W-1:0] e_rob_id   [DEPTH];
    logic [ROB_W-1:0] e_base_tag [DEPTH];
    logic [ROB_W-1:0] e_data_tag [DEPTH];
    logic [XLEN-1:0]  e_addr     [DEPTH];
    logic [XLEN-1:0]  e_data     [DEPTH];
    logic [XLEN:0]    base_snp   [DEPTH];
    logic [XLEN:0]    data_snp   [DEPTH];
    logic [XLEN:0]    enq_base_snp, enq_data_snp;
    logic             enq, ld_ok, mem_ok, issue, commit, deq;
    logic             enq_addr_rdy, enq_drdy;
    logic [XLEN-1:0]  enq_addr, enq_dval;

    // {hit, value}; iterating from the top down lets the lowest matching channel win
    function automatic logic [XLEN:0] snoop(input logic [ROB_W-1:0] t, input logic [NUM_CDB-1:0] v,
                                            input logic [NUM_CDB*ROB_W-1:0] tg, input logic [NUM_CDB*XLEN-1:0] vl);
        snoop = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--)
            if (v[k] && tg[k*ROB_W +: ROB_W] == t) snoop = {1'b1, vl[k*XLEN +: XLEN]};
    endfunction

    assign full           = count == CW'(DEPTH);
    assign empty          = count == '0;
    assign front_is_load  = e_is_load[head];
    assign front_op       = e_op[head];
    assign front_rob_id   = e_rob_id[head];
    assign front_addr_rdy = e_addr_rdy[head];
    assign front_addr     = e_addr[head];
    assign front_data_rdy = e_data_rdy[head];
    assign front_data     = e_data[head];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            base_snp[i] = snoop(e_base_tag[i], cdb_valid, cdb_tag, cdb_val);
            data_snp[i] = snoop(e_data_tag[i], cdb_valid, cdb_tag, cdb_val);
        end
    end

    always_comb begin
        enq_base_snp = snoop(enq_base_tag, cdb_valid, cdb_tag, cdb_val);
        enq_data_snp = snoop(enq_data_tag, cdb_valid, cdb_tag, cdb_val);
        enq_addr_rdy = enq_base_rdy | enq_base_snp[XLEN];
        enq_addr     = enq_base_rdy ? enq_imm + enq_base_val :
                       enq_base_snp[XLEN] ? enq_imm + enq_base_snp[XLEN-1:0] : enq_imm;
        enq_drdy     = enq_is_load | enq_data_rdy | enq_data_snp[XLEN];
        enq_dval     = enq_is_load ? '0 : enq_data_rdy ? enq_data_val :
                       enq_data_snp[XLEN] ? enq_data_snp[XLEN-1:0] : '0;
    end

    assign enq    = enq_valid & ~stall & ~full & ~flush;
    assign ld_ok  = e_valid[head] & e_is_load[head] & e_addr_rdy[head] & ~flush;
    assign mem_ok = ld_ok & ~mem_busy & ~((e_addr[head] == IO_ADDR) & io_full);
    assign commit = commit_store & e_valid[head] & ~e_is_load[head] & ~flush;

`ifdef LSB_STORE_FWD_EN
    logic            fwd_hit, fwd_go;
    logic [XLEN-1:0] fwd_data;
    logic [IW-1:0]   fidx;

    // Scan from just behind the head towards the tail so the youngest matching store wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fidx     = head;
        for (int i = 1; i < DEPTH; i++) begin
            fidx = head + IW'(i);
            if (e_valid[fidx] && !e_is_load[fidx] && e_addr_rdy[fidx] && e_data_rdy[fidx] &&
                e_addr[fidx] == e_addr[head] && e_op[fidx] == e_op[head]) begin
                fwd_hit  = 1'b1;
                fwd_data = e_data[fidx];
            end
        end
    end

    assign fwd_go = ld_ok & fwd_hit;
    assign issue  = mem_ok & ~fwd_hit;
    assign deq    = issue | fwd_go | commit;

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst || flush) begin
                fwd_valid <= 1'b0;
                if (rst) begin
                    fwd_val    <= '0;
                    fwd_rob_id <= '0;
                end
            end else begin
                fwd_valid <= fwd_go;
                if (fwd_go) begin
                    fwd_val    <= fwd_data;
                    fwd_rob_id <= e_rob_id[head];
                end
            end
        end
    end
`else
    assign issue = mem_ok;
    assign deq   = issue | commit;
`endif

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                mem_req_valid  <= 1'b0;
                mem_req_op     <= '0;
                mem_req_addr   <= '0;
                mem_req_rob_id <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    e_valid[i]    <= 1'b0;
                    e_is_load[i]  <= 1'b0;
                    e_addr_rdy[i] <= 1'b0;
                    e_data_rdy[i] <= 1'b0;
                    e_op[i]       <= '0;
                    e_rob_id[i]   <= '0;
                    e_base_tag[i] <= '0;
                    e_data_tag[i] <= '0;
                    e_addr[i]     <= '0;
                    e_data[i]     <= '0;
                end
            end else if (flush) begin
                tail          <= head;
                count         <= '0;
                mem_req_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++) e_valid[i] <= 1'b0;
            end else begin
                mem_req_valid <= issue;
                if (issue) begin
                    mem_req_op     <= e_op[head];
                    mem_req_addr   <= e_addr[head];
                    mem_req_rob_id <= e_rob_id[head];
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (e_valid[i] && !e_addr_rdy[i] && base_snp[i][XLEN]) begin
                        e_addr_rdy[i] <= 1'b1;
                        e_addr[i]     <= e_addr[i] + base_snp[i][XLEN-1:0];
                    end
                    if (e_valid[i] && !e_data_rdy[i] && data_snp[i][XLEN]) begin
                        e_data_rdy[i] <= 1'b1;
                        e_data[i]     <= data_snp[i][XLEN-1:0];
                    end
                end
                if (enq) begin
                    e_valid[tail]    <= 1'b1;
                    e_is_load[tail]  <= enq_is_load;
                    e_op[tail]       <= enq_op;
                    e_rob_id[tail]   <= enq_rob_id;
                    e_addr_rdy[tail] <= enq_addr_rdy;
                    e_addr[tail]     <= enq_addr;
                    e_base_tag[tail] <= enq_base_tag;
                    e_data_rdy[tail] <= enq_drdy;
                    e_data[tail]     <= enq_dval;
                    e_data_tag[tail] <= enq_data_tag;
                    tail             <= tail + 1'b1;
                end
                if (deq) begin
                    e_valid[head] <= 1'b0;
                    head          <= head + 1'b1;
                end
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end
endmodule
